// File: rtl/stream_rr_dist_pkg.sv
// stream_rr_dist_pkg
//   Shared defaults and a reference round-robin search for the
//   stream_rr_distributor block.
//   - NumOutDefault / DataWidthDefault : default parameter values.
//   - MaxNumOut                        : widest enable mask next_enabled_idx accepts.
//   - next_enabled_idx(rr, en, num_out): first enabled port after rr, with wrap-around.
package stream_rr_dist_pkg;

  localparam int unsigned NumOutDefault    = 4;
  localparam int unsigned DataWidthDefault = 32;
  localparam int unsigned MaxNumOut        = 32;

  // Scans rr+1 .. num_out-1, then 0 .. rr. rr is picked only when it is
  // the sole enabled port. Returns 0 when nothing is enabled.
  function automatic int unsigned next_enabled_idx(
    input int unsigned          rr,
    input logic [MaxNumOut-1:0] en,
    input int unsigned          num_out
  );
    int unsigned j;
    next_enabled_idx = 0;
    for (int unsigned k = num_out; k >= 1; k--) begin
      j = (rr + k) % num_out;
      if (en[j]) next_enabled_idx = j;
    end
  endfunction

endpackage

// File: rtl/stream_rr_dist_sel.sv
// stream_rr_dist_sel
//   Combinational wrap-around search for the next target port.
//   Ports:
//     en       in  [NumOut-1:0]   enable mask
//     rr       in  [IdxWidth-1:0] last loaded target
//     next_idx out [IdxWidth-1:0] first enabled port after rr (wrapping)
//     any_en   out                at least one port enabled
module stream_rr_dist_sel
  import stream_rr_dist_pkg::*;
#(
  parameter int unsigned NumOut   = NumOutDefault,
  parameter int unsigned IdxWidth = (NumOut > 1) ? $clog2(NumOut) : 1
) (
  input  logic [NumOut-1:0]   en,
  input  logic [IdxWidth-1:0] rr,
  output logic [IdxWidth-1:0] next_idx,
  output logic                any_en
);

  logic [NumOut-1:0]   upper_mask;
  logic [NumOut-1:0]   lower_mask;
  logic [IdxWidth-1:0] upper_idx;
  logic [IdxWidth-1:0] lower_idx;
  logic                upper_any;
  logic                lower_any;

  // Split the enables around rr: ports after rr have priority, the ports
  // up to and including rr are only used once the upper half is empty.
  for (genvar gi = 0; gi < NumOut; gi++) begin : g_mask
    assign upper_mask[gi] = en[gi] & (IdxWidth'(gi) >  rr);
    assign lower_mask[gi] = en[gi] & (IdxWidth'(gi) <= rr);
  end

  // Two lowest-set-bit encoders; iterating downward lets the lowest index win.
  always_comb begin
    upper_idx = '0;
    upper_any = 1'b0;
    lower_idx = '0;
    lower_any = 1'b0;
    for (int i = NumOut - 1; i >= 0; i--) begin
      if (upper_mask[i]) begin
        upper_idx = IdxWidth'(i);
        upper_any = 1'b1;
      end
      if (lower_mask[i]) begin
        lower_idx = IdxWidth'(i);
        lower_any = 1'b1;
      end
    end
  end

  assign next_idx = upper_any ? upper_idx : lower_idx;
  assign any_en   = upper_any | lower_any;

endmodule

// File: rtl/stream_rr_distributor.sv
// stream_rr_distributor
//   Spreads one valid/ready stream over NumOut ports in round-robin order,
//   skipping ports masked off by en_i. The output slot is registered, so
//   valid_o/data_o/idx_o stay stable until the item is taken.
//   Optional macro STREAM_RR_DIST_SPILL_EN adds a one-entry skid in front of
//   the slot so ready_o no longer depends combinationally on ready_i.
//   Ports:
//     clk_i, rst_ni  clock (rising edge), asynchronous active-low reset
//     flush_i        synchronous drop of held items and round-robin state
//     en_i           per-port enable mask for target selection
//     valid_i/ready_o/data_i   upstream stream
//     valid_o/ready_i          per-port handshake, valid_o one-hot or zero
//     data_o         payload, broadcast to all ports
//     idx_o          target port of the held item
module stream_rr_distributor
  import stream_rr_dist_pkg::*;
#(
  parameter int unsigned NumOut    = NumOutDefault,
  parameter int unsigned DataWidth = DataWidthDefault,
  parameter type         DataType  = logic [DataWidth-1:0],
  parameter int unsigned IdxWidth  = (NumOut > 1) ? $clog2(NumOut) : 1,
  parameter type         idx_t     = logic [IdxWidth-1:0]
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic [NumOut-1:0] en_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  DataType           data_i,
  output logic [NumOut-1:0] valid_o,
  input  logic [NumOut-1:0] ready_i,
  output DataType           data_o,
  output idx_t              idx_o
);

  localparam idx_t RrReset = idx_t'(NumOut - 1);

  logic    slot_valid_q;
  DataType slot_data_q;
  idx_t    slot_tgt_q;
  idx_t    rr_q;

  idx_t    next_idx;
  logic    any_en;
  logic    pop;
  logic    accept;
  logic    slot_load;
  DataType slot_load_data;

  stream_rr_dist_sel #(
    .NumOut  (NumOut),
    .IdxWidth(IdxWidth)
  ) i_sel (
    .en      (en_i),
    .rr      (rr_q),
    .next_idx(next_idx),
    .any_en  (any_en)
  );

  assign pop    = slot_valid_q & ready_i[slot_tgt_q];
  assign accept = valid_i & ready_o;

`ifdef STREAM_RR_DIST_SPILL_EN
  logic    skid_valid_q;
  DataType skid_data_q;
  logic    slot_free;
  logic    skid_drain;
  logic    skid_load;

  // The skid always drains before new input reaches the slot, which keeps
  // order. A skid item waits if no port is enabled, since it has no target yet.
  assign slot_free      = ~slot_valid_q | pop;
  assign ready_o        = any_en & ~flush_i & ~skid_valid_q;
  assign skid_drain     = skid_valid_q & slot_free & any_en;
  assign slot_load      = skid_drain | (accept & slot_free);
  assign slot_load_data = skid_valid_q ? skid_data_q : data_i;
  assign skid_load      = accept & ~slot_free;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else if (flush_i) begin
      skid_valid_q <= 1'b0;
    end else if (skid_load) begin
      skid_valid_q <= 1'b1;
      skid_data_q  <= data_i;
    end else if (skid_drain) begin
      skid_valid_q <= 1'b0;
    end
  end
`else
  assign ready_o        = any_en & ~flush_i & (~slot_valid_q | pop);
  assign slot_load      = accept;
  assign slot_load_data = data_i;
`endif

  // Target is fixed at load time; en_i changes never retarget a held item.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_valid_q <= 1'b0;
      slot_data_q  <= '0;
      slot_tgt_q   <= '0;
      rr_q         <= RrReset;
    end else if (flush_i) begin
      slot_valid_q <= 1'b0;
      rr_q         <= RrReset;
    end else if (slot_load) begin
      slot_valid_q <= 1'b1;
      slot_data_q  <= slot_load_data;
      slot_tgt_q   <= next_idx;
      rr_q         <= next_idx;
    end else if (pop) begin
      slot_valid_q <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < NumOut; gi++) begin : g_valid
    assign valid_o[gi] = slot_valid_q & (slot_tgt_q == idx_t'(gi));
  end

  assign data_o = slot_data_q;
  assign idx_o  = slot_tgt_q;

endmodule

// File: doc/stream_rr_distributor.md
Name: stream_rr_distributor

Overview:
- 1:N counterpart of the round-robin arbitration tree: takes one valid/ready stream and spreads transactions over NumOut downstream ports in round-robin order.
- Skips ports masked off by en_i.
- Registered output slot: valid_o/data_o/idx_o come from flops and are AXI-stable.
- Sits in front of replicated workers (e.g. banked units fed from one request source).

Parameters:
- NumOut, 4, number of output ports (>=1).
- DataWidth, 32, payload width in bits; ignored if DataType is overridden.
- DataType, logic [DataWidth-1:0], payload type.
- IdxWidth, (NumOut>1) ? $clog2(NumOut) : 1, dependent parameter; do not override.
- idx_t, logic [IdxWidth-1:0], dependent parameter; do not override.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous reset, active low.
- flush_i  input  1  synchronous clear of held data and round-robin state.
- en_i  input  NumOut  per-port enable mask for target selection.
- valid_i  input  1  upstream valid.
- ready_o  output  1  upstream ready.
- data_i  input  DataType  upstream payload.
- valid_o  output  NumOut  per-port valid, one-hot or zero.
- ready_i  input  NumOut  per-port ready.
- data_o  output  DataType  payload, broadcast to all ports.
- idx_o  output  idx_t  target port of the held item.

Behaviour:
- State: slot_valid_q, slot_data_q, slot_tgt_q, rr_q (last loaded target).
- Reset values: slot_valid_q=0, slot_data_q='0, slot_tgt_q=0, rr_q=NumOut-1. After reset, valid_o='0, data_o='0, idx_o=0, and the first target is port 0.
- next_idx: first index j with en_i[j]=1, scanning rr_q+1 ... NumOut-1, then 0 ... rr_q (wrap).
  - rr_q itself is chosen only if it is the sole enabled port.
  - any_en = |en_i.
- pop = slot_valid_q & ready_i[slot_tgt_q].
- ready_o = any_en & ~flush_i & (~slot_valid_q | pop). Full throughput: 1 item/cycle when targets are ready.
- Load on valid_i & ready_o:
  - slot_data_q <= data_i, slot_tgt_q <= next_idx, rr_q <= next_idx, slot_valid_q <= 1.
  - Latency input -> output is 1 cycle.
- Pop without load: slot_valid_q <= 0. Simultaneous pop and load: slot stays valid with the new item.
- valid_o[i] = slot_valid_q & (slot_tgt_q==i). idx_o = slot_tgt_q. data_o = slot_data_q.
- A loaded item never changes target or data until popped (AXI stability), even if en_i[slot_tgt_q] drops.
- en_i affects only future selections.
- en_i all zero: ready_o=0; a held item still drains.
- flush_i (sync): slot_valid_q <= 0, rr_q <= NumOut-1; the held item is dropped. Flush dominates load and pop in the same cycle.
- Reset asserted mid-transfer: held item is lost and outputs return to reset values immediately (async).
- NumOut==1: next_idx=0 always; behaves as a single-stage pipeline register gated by en_i[0].
- Upstream rule: valid_i must not depend on ready_o, and data_i stays stable while valid_i & ~ready_o.

Optional Feature:
- Macro: STREAM_RR_DIST_SPILL_EN.
- Defined:
  - Adds a one-entry skid register in front of the slot.
  - ready_o = any_en & ~flush_i & ~skid_valid_q, which breaks the combinational ready_i -> ready_o path.
  - Order is preserved; the target is assigned when an item enters the slot.
  - Latency is still 1 cycle when the skid is empty.
  - flush clears both entries.
- Undefined: single slot, combinational ready_o as above.

Decomposition:
- Package stream_rr_dist_pkg:
  - function next_enabled_idx(rr, en, NumOut) for reuse by the bench model;
  - localparam defaults.
- Sub-module stream_rr_dist_sel: combinational wrap-around search, two lzc instances (upper mask i>rr_q, lower mask i<=rr_q) giving next_idx and any_en.
- Top holds the slot, the optional skid and rr_q.

Test Plan:
- Reset then NumOut=4, en_i=4'hF, valid_i=1, all ready_i=1 for 8 cycles with data 0..7 -> idx_o sequence 0,1,2,3,0,1,2,3 from cycle 1; ready_o=1 every cycle; each data appears once on valid_o.
- en_i=4'b1010, continuous input -> targets alternate 1,3,1,3; valid_o[0] and valid_o[2] never asserted.
- Item to port 2 with ready_i[2]=0 for 5 cycles, en_i[2] dropped in cycle 2 -> valid_o=4'b0100, idx_o=2 and data stable for all 5 cycles; ready_o=0 (no spill); pops when ready_i[2]=1; next target is 3.
- en_i=0 with valid_i=1 -> ready_o=0, no loads; restore en_i=4'b0001 -> target 0.
- flush_i while holding an item targeted at 1, with valid_i=1 the same cycle -> next cycle valid_o=0, nothing loaded; next load targets 0.
- With STREAM_RR_DIST_SPILL_EN, hold all ready_i=0 and stream 3 items -> ready_o drops after 2 accepted; release -> items drain in order to ports 0,1 then the third goes to 2; assert no ready_i -> ready_o combinational path (structural check).
